horner_sequencer: RTL and testbench
===================================

Name: horner_sequencer

Overview:
Controller that evaluates a polynomial of degree 0..MAX_DEG at a point x using Horner's rule: acc = k[d]; then repeat acc = acc*x + k[i].
It holds the coefficient register file and the accumulator, and it drives the shared add/multiply ALU through external select/operand ports.
It sits between the switch/key front-end and the existing add/mul ALU, and generalises the fixed A·x²+B·x+C sequence to a runtime-selected degree.

Parameters:
WIDTH, 8, data width of coefficients, x, accumulator and result
MAX_DEG, 3, highest supported degree; coefficient file holds MAX_DEG+1 entries

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-high reset
load_valid  in  1  coefficient write request
load_ready  out  1  high when a write is accepted (IDLE only)
load_addr  in  clog2(MAX_DEG+1)  coefficient index k[load_addr]
load_data  in  WIDTH  coefficient value
start  in  1  begin evaluation; sampled only in IDLE
degree  in  clog2(MAX_DEG+1)  polynomial degree d, latched on start
x_in  in  WIDTH  evaluation point, latched on start
busy  out  1  evaluation in progress
done  out  1  one-cycle pulse when result is updated
result  out  WIDTH  registered evaluation result
alu_op  out  1  0 = add, 1 = multiply
alu_a  out  WIDTH  ALU operand A
alu_b  out  WIDTH  ALU operand B
alu_y  in  WIDTH  combinational ALU result, same cycle, low WIDTH bits

Behaviour:
- Reset (clk edge with reset=1):
  - state = IDLE.
  - All coefficients, acc, x, the index counter and result = 0.
  - done = 0, busy = 0, load_ready = 1 after reset is released.
  - Reset wins over every other input and aborts any evaluation in progress; no done pulse follows.
- States: IDLE, MUL, ADD, DONE.
- IDLE:
  - load_ready = 1. A write to k[load_addr] occurs when load_valid=1.
  - On start=1, at that edge: x <= x_in, d <= degree, acc <= k[degree], i <= degree.
  - Next state is MUL if degree != 0, else DONE.
  - If degree > MAX_DEG (non-power-of-two MAX_DEG only), it is clamped to MAX_DEG.
- Load and start on the same edge: the write takes effect, but the acc snapshot uses the pre-write coefficient value.
- MUL: alu_op=1, alu_a=acc, alu_b=x; acc <= alu_y; next state ADD.
- ADD: alu_op=0, alu_a=acc, alu_b=k[i-1]; acc <= alu_y; i <= i-1; next state DONE if i-1 == 0, else MUL.
- DONE: result <= acc; done = 1 for this cycle only; next state IDLE.
- IDLE/DONE ALU drive: alu_op=0, alu_a=0, alu_b=0.
- busy = 1 in MUL, ADD and DONE; 0 in IDLE. load_ready = ~busy.
- Busy-time inputs: start is ignored while busy. load_valid while busy is ignored and the coefficient is unchanged.
- Latency: start sampled at edge 0 → MUL/ADD occupy cycles 1..2d → DONE (done=1) in cycle 2d+1, where result is visible from the following edge.
  - d=0: done in cycle 1.
  - Back-to-back: start may be accepted in the first IDLE cycle after DONE.
- Arithmetic: all operations are modulo 2^WIDTH; overflow is silently truncated (the ALU returns the low WIDTH bits).
- result holds its value until the next DONE or reset. Coefficients persist across evaluations.

Decomposition:
- Shared package:
  - State enum (IDLE, MUL, ADD, DONE).
  - ALU opcode constants (ALU_ADD=0, ALU_MUL=1).
  - Default WIDTH/MAX_DEG.
- One natural sub-module: horner_coef_rf. It holds MAX_DEG+1 × WIDTH registers with synchronous write, two combinational read ports (k[degree] for start, k[i-1] for ADD) and synchronous clear on reset.
- The FSM, counter and accumulator stay in horner_sequencer.
- The ALU is external; the bench supplies a combinational add/mul model.

Test Plan:
- k2=2, k1=3, k0=5; start, degree=2, x_in=4 → result=49 (0x31); done high exactly in cycle 5 after start; busy high in cycles 1–5.
- k0=0x2A; start, degree=0, x_in=7 → done in cycle 1, result=0x2A; no cycle with alu_op=1.
- k1=0x20, k0=0x01, degree=1, x_in=0x10 → 0x200+1 truncates to result=0x01.
- During evaluation: assert start (with a different degree) and load_valid to k0 → start and load ignored, load_ready=0, original result unchanged, k0 unchanged when read by a later evaluation.
- Reset in the MUL cycle of a degree-3 evaluation → next cycle IDLE, busy=0, result=0, no done pulse; a subsequent evaluation sees all coefficients = 0 → result 0.
- load k2=9 and start degree=2 on the same edge with old k2=1, k1=0, k0=0, x=3 → result=9 (uses old k2). A repeat start gives 81.

Source files
------------

// File: rtl/horner_sequencer_pkg.sv
// Shared types and constants for the Horner polynomial sequencer.
// Imported by the coefficient file, the sequencer top and the bench.
package horner_sequencer_pkg;

   localparam int DEF_WIDTH   = 8;
   localparam int DEF_MAX_DEG = 3;

   localparam logic ALU_ADD = 1'b0;
   localparam logic ALU_MUL = 1'b1;

   typedef enum logic [1:0] {
      S_IDLE,
      S_MUL,
      S_ADD,
      S_DONE
   } state_t;

endpackage

// File: rtl/horner_coef_rf.sv
// Coefficient register file: MAX_DEG+1 entries, one synchronous write port,
// two combinational read ports (start snapshot and ADD-step operand).
module horner_coef_rf
   import horner_sequencer_pkg::*;
#(
   parameter int WIDTH   = DEF_WIDTH,
   parameter int MAX_DEG = DEF_MAX_DEG,
   parameter int AW      = (MAX_DEG > 0) ? $clog2(MAX_DEG + 1) : 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             wr_en,
   input  logic [AW-1:0]    wr_addr,
   input  logic [WIDTH-1:0] wr_data,
   input  logic [AW-1:0]    rd_start_addr,
   output logic [WIDTH-1:0] rd_start_data,
   input  logic [AW-1:0]    rd_add_addr,
   output logic [WIDTH-1:0] rd_add_data
);

   logic [WIDTH-1:0] mem [0:MAX_DEG];

   // NOTE: non-blocking assignments for all state; the whole file is cleared
   // on reset because a fresh evaluation must see zero coefficients.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i <= MAX_DEG; i++) begin
            mem[i] <= '0;
         end
      end else if (wr_en && (wr_addr <= AW'(MAX_DEG))) begin
         mem[wr_addr] <= wr_data;
      end
   end

   // Reads see the pre-write contents, so a same-edge load cannot leak into
   // the start snapshot.
   assign rd_start_data = (rd_start_addr <= AW'(MAX_DEG)) ? mem[rd_start_addr] : '0;
   assign rd_add_data   = (rd_add_addr   <= AW'(MAX_DEG)) ? mem[rd_add_addr]   : '0;

endmodule

// File: rtl/horner_sequencer.sv
// Horner's-rule polynomial evaluator: owns coefficients, accumulator and
// index counter, and sequences an external combinational add/mul ALU.
module horner_sequencer
   import horner_sequencer_pkg::*;
#(
   parameter int WIDTH   = DEF_WIDTH,
   parameter int MAX_DEG = DEF_MAX_DEG,
   parameter int AW      = (MAX_DEG > 0) ? $clog2(MAX_DEG + 1) : 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load_valid,
   output logic             load_ready,
   input  logic [AW-1:0]    load_addr,
   input  logic [WIDTH-1:0] load_data,
   input  logic             start,
   input  logic [AW-1:0]    degree,
   input  logic [WIDTH-1:0] x_in,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             alu_op,
   output logic [WIDTH-1:0] alu_a,
   output logic [WIDTH-1:0] alu_b,
   input  logic [WIDTH-1:0] alu_y
);

   state_t           state;
   state_t           state_nxt;
   logic [WIDTH-1:0] acc;
   logic [WIDTH-1:0] x_reg;
   logic [WIDTH-1:0] result_q;
   logic [AW-1:0]    idx;
   logic [AW-1:0]    idx_dec;
   logic [AW-1:0]    deg_eff;
   logic [WIDTH-1:0] k_start;
   logic [WIDTH-1:0] k_add;
   logic             wr_en;

   assign deg_eff = (degree > AW'(MAX_DEG)) ? AW'(MAX_DEG) : degree;
   assign idx_dec = idx - 1'b1;
   assign wr_en   = (state == S_IDLE) && load_valid;

   horner_coef_rf #(
      .WIDTH   (WIDTH),
      .MAX_DEG (MAX_DEG),
      .AW      (AW)
   ) u_coef_rf (
      .clk           (clk),
      .reset         (reset),
      .wr_en         (wr_en),
      .wr_addr       (load_addr),
      .wr_data       (load_data),
      .rd_start_addr (deg_eff),
      .rd_start_data (k_start),
      .rd_add_addr   (idx_dec),
      .rd_add_data   (k_add)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // NOTE: every output of this block gets a default first so no latch is inferred.
   always_comb begin
      state_nxt = state;
      alu_op    = ALU_ADD;
      alu_a     = '0;
      alu_b     = '0;
      case (state)
         S_IDLE: begin
            if (start) begin
               state_nxt = (deg_eff != '0) ? S_MUL : S_DONE;
            end
         end
         S_MUL: begin
            alu_op    = ALU_MUL;
            alu_a     = acc;
            alu_b     = x_reg;
            state_nxt = S_ADD;
         end
         S_ADD: begin
            alu_a     = acc;
            alu_b     = k_add;
            state_nxt = (idx_dec == '0) ? S_DONE : S_MUL;
         end
         S_DONE: begin
            state_nxt = S_IDLE;
         end
         default: begin
            state_nxt = S_IDLE;
         end
      endcase
   end

   // The index counter doubles as the latched degree: it starts at d and
   // walks down to 0 one ADD step at a time.
   always_ff @(posedge clk) begin
      if (reset) begin
         acc      <= '0;
         x_reg    <= '0;
         idx      <= '0;
         result_q <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (start) begin
                  x_reg <= x_in;
                  idx   <= deg_eff;
                  acc   <= k_start;
               end
            end
            S_MUL: begin
               acc <= alu_y;
            end
            S_ADD: begin
               acc <= alu_y;
               idx <= idx_dec;
            end
            S_DONE: begin
               result_q <= acc;
            end
            default: begin
            end
         endcase
      end
   end

   assign busy       = (state != S_IDLE);
   assign done       = (state == S_DONE);
   assign load_ready = ~busy;
   assign result     = result_q;

endmodule

// File: tb/tb_horner_sequencer.sv
// Directed bench for horner_sequencer with a combinational add/mul ALU model;
// expected values are hand-computed polynomial evaluations.
module tb_horner_sequencer;
   import horner_sequencer_pkg::*;

   localparam int WIDTH   = 8;
   localparam int MAX_DEG = 3;
   localparam int AW      = 2;

   logic             clk = 1'b0;
   logic             reset;
   logic             load_valid;
   logic             load_ready;
   logic [AW-1:0]    load_addr;
   logic [WIDTH-1:0] load_data;
   logic             start;
   logic [AW-1:0]    degree;
   logic [WIDTH-1:0] x_in;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] result;
   logic             alu_op;
   logic [WIDTH-1:0] alu_a;
   logic [WIDTH-1:0] alu_b;
   logic [WIDTH-1:0] alu_y;

   int n_cmp = 0;
   int n_err = 0;
   int muls;
   int pulses;

   always #5 clk = ~clk;

   horner_sequencer #(
      .WIDTH   (WIDTH),
      .MAX_DEG (MAX_DEG),
      .AW      (AW)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .load_valid (load_valid),
      .load_ready (load_ready),
      .load_addr  (load_addr),
      .load_data  (load_data),
      .start      (start),
      .degree     (degree),
      .x_in       (x_in),
      .busy       (busy),
      .done       (done),
      .result     (result),
      .alu_op     (alu_op),
      .alu_a      (alu_a),
      .alu_b      (alu_b),
      .alu_y      (alu_y)
   );

   // External ALU: low WIDTH bits of add or multiply
   assign alu_y = (alu_op == ALU_MUL) ? WIDTH'(alu_a * alu_b) : WIDTH'(alu_a + alu_b);

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic load(input logic [AW-1:0] addr, input logic [WIDTH-1:0] data);
      load_valid = 1'b1;
      load_addr  = addr;
      load_data  = data;
      step();
      load_valid = 1'b0;
   endtask

   task automatic start_eval(input logic [AW-1:0] deg, input logic [WIDTH-1:0] x);
      start  = 1'b1;
      degree = deg;
      x_in   = x;
      step();
      start  = 1'b0;
   endtask

   // Entered in cycle start_cyc after the start edge; returns one cycle past DONE.
   task automatic wait_done(input string tag, input int start_cyc, input int exp_cyc,
                            output int mul_cycles);
      int cyc;
      bit found;
      cyc        = start_cyc;
      found      = 1'b0;
      mul_cycles = 0;
      while (!found && cyc < 40) begin
         if (alu_op === ALU_MUL) mul_cycles++;
         if (done === 1'b1) begin
            found = 1'b1;
         end else begin
            step();
            cyc++;
         end
      end
      check({tag, "_done_cycle"}, found ? cyc : 32'hFFFF_FFFF, exp_cyc);
      step();
   endtask

   initial begin
      reset      = 1'b1;
      load_valid = 1'b0;
      load_addr  = '0;
      load_data  = '0;
      start      = 1'b0;
      degree     = '0;
      x_in       = '0;
      step();
      step();
      reset = 1'b0;

      // Reset state
      check("rst_busy", busy, 1'b0);
      check("rst_done", done, 1'b0);
      check("rst_ready", load_ready, 1'b1);
      check("rst_result", result, 8'h00);
      check("rst_alu_op", alu_op, 1'b0);
      check("rst_alu_a", alu_a, 8'h00);
      check("rst_alu_b", alu_b, 8'h00);

      // 2x^2 + 3x + 5 at x=4 = 49, with exact cycle timing
      load(2'd2, 8'd2);
      load(2'd1, 8'd3);
      load(2'd0, 8'd5);
      start_eval(2'd2, 8'd4);
      for (int c = 1; c <= 5; c++) begin
         check($sformatf("t1_busy_c%0d", c), busy, 1'b1);
         check($sformatf("t1_done_c%0d", c), done, (c == 5));
         if (c == 1) begin
            check("t1_c1_op", alu_op, 1'b1);
            check("t1_c1_a", alu_a, 8'd2);
            check("t1_c1_b", alu_b, 8'd4);
         end
         if (c == 2) begin
            check("t1_c2_op", alu_op, 1'b0);
            check("t1_c2_a", alu_a, 8'd8);
            check("t1_c2_b", alu_b, 8'd3);
         end
         step();
      end
      check("t1_busy_c6", busy, 1'b0);
      check("t1_done_c6", done, 1'b0);
      check("t1_result", result, 8'h31);

      // Degree 0: immediate DONE, no multiply
      load(2'd0, 8'h2A);
      start_eval(2'd0, 8'd7);
      wait_done("t2", 1, 1, muls);
      check("t2_mul_cycles", muls, 0);
      check("t2_result", result, 8'h2A);

      // Overflow: 0x20*0x10 + 1 truncates to 0x01
      load(2'd1, 8'h20);
      load(2'd0, 8'h01);
      start_eval(2'd1, 8'h10);
      wait_done("t3", 1, 3, muls);
      check("t3_mul_cycles", muls, 1);
      check("t3_result", result, 8'h01);

      // Start and load while busy are ignored
      start_eval(2'd1, 8'd2);
      start      = 1'b1;
      degree     = 2'd2;
      x_in       = 8'd9;
      load_valid = 1'b1;
      load_addr  = 2'd0;
      load_data  = 8'h77;
      check("t4_ready_busy", load_ready, 1'b0);
      step();
      start      = 1'b0;
      load_valid = 1'b0;
      check("t4_add_operand", alu_b, 8'h01);
      wait_done("t4", 2, 3, muls);
      check("t4_result", result, 8'h41);
      check("t4_idle_after", busy, 1'b0);
      start_eval(2'd0, 8'd0);
      wait_done("t4b", 1, 1, muls);
      check("t4_k0_kept", result, 8'h01);

      // Reset during MUL of a degree-3 evaluation
      load(2'd3, 8'd1);
      start_eval(2'd3, 8'd2);
      check("t5_in_mul", alu_op, 1'b1);
      reset = 1'b1;
      step();
      reset = 1'b0;
      check("t5_busy", busy, 1'b0);
      check("t5_done", done, 1'b0);
      check("t5_ready", load_ready, 1'b1);
      check("t5_result", result, 8'h00);
      pulses = 0;
      for (int c = 0; c < 8; c++) begin
         if (done === 1'b1) pulses++;
         step();
      end
      check("t5_no_done", pulses, 0);
      start_eval(2'd3, 8'd5);
      wait_done("t5b", 1, 7, muls);
      check("t5b_mul_cycles", muls, 3);
      check("t5b_result", result, 8'h00);

      // Same-edge load and start: snapshot uses the old k2
      load(2'd2, 8'd1);
      load_valid = 1'b1;
      load_addr  = 2'd2;
      load_data  = 8'd9;
      start      = 1'b1;
      degree     = 2'd2;
      x_in       = 8'd3;
      step();
      load_valid = 1'b0;
      start      = 1'b0;
      wait_done("t6", 1, 5, muls);
      check("t6_result", result, 8'd9);
      start_eval(2'd2, 8'd3);
      wait_done("t6b", 1, 5, muls);
      check("t6b_result", result, 8'd81);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
